// File: rtl/mem_lsu.sv
// MEM stage load/store unit: issues one data-memory request per aligned memory op,
// stalls the pipe until it completes, and produces the registered MEM/WB outputs.
module mem_lsu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_fwd_data,
  input  logic [31:0] i_instruction,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic        i_mem_to_reg,
  output logic        o_stall,
  output logic        o_dmem_req_valid,
  input  logic        i_dmem_req_ready,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wmask,
  output logic        o_dmem_wen,
  input  logic        i_dmem_rsp_valid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_reg_write,
  output logic        o_trap_misaligned,
  output logic [4:0]  o_wb_rd_addr,
  output logic [31:0] o_wb_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_mask = 4'b0001 << off;
      2'b01:   store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = rd;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        wen_q, wen_d, rw_q, rw_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_valid_d, wb_rw_d, wb_trap_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;

  logic [2:0] funct3;
  logic       mem_op, is_half, is_word, misaligned, aligned_mem, complete;
  logic       unused_ok;

  assign funct3      = i_instruction[14:12];
  assign mem_op      = i_valid & (i_mem_read | i_mem_write);
  assign is_half     = (funct3[1:0] == 2'b01);
  assign is_word     = funct3[1];
  assign misaligned  = mem_op & ((is_half & i_alu_result[0]) |
                                 (is_word & (i_alu_result[1:0] != 2'b00)));
  assign aligned_mem = mem_op & ~misaligned;
  assign complete    = ((state_q == REQ) & i_dmem_req_ready & wen_q) |
                       ((state_q == RSP) & i_dmem_rsp_valid);
  assign o_stall     = aligned_mem & ~complete;
  assign unused_ok   = ^{i_mem_to_reg, i_instruction[31:15], i_instruction[11:0]};

  assign o_dmem_req_valid = (state_q == REQ);
  assign o_dmem_addr      = addr_q;
  assign o_dmem_wdata     = wdata_q;
  assign o_dmem_wmask     = wmask_q;
  assign o_dmem_wen       = wen_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    wen_d      = wen_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = 1'b0;
    wb_trap_d  = 1'b0;
    wb_rd_d    = 5'd0;
    wb_data_d  = 32'd0;
    case (state_q)
      IDLE: begin
        if (aligned_mem) begin
          state_d = REQ;
          addr_d  = {i_alu_result[31:2], 2'b00};
          wdata_d = store_data(funct3, i_rs2_fwd_data);
          wmask_d = i_mem_write ? store_mask(funct3, i_alu_result[1:0]) : 4'b0000;
          wen_d   = i_mem_write;
          f3_d    = funct3;
          off_d   = i_alu_result[1:0];
          rd_d    = i_rd_addr;
          rw_d    = i_reg_write;
        end else if (misaligned) begin
          wb_valid_d = 1'b1;
          wb_trap_d  = 1'b1;
          wb_rd_d    = i_rd_addr;
        end else if (i_valid) begin
          wb_valid_d = 1'b1;
          wb_rw_d    = i_reg_write;
          wb_rd_d    = i_rd_addr;
          wb_data_d  = i_alu_result;
        end
      end
      REQ: begin
        if (i_dmem_req_ready) begin
          if (wen_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_rw_d    = rw_q;
            wb_rd_d    = rd_q;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (i_dmem_rsp_valid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rw_d    = rw_q;
          wb_rd_d    = rd_q;
          wb_data_d  = load_ext(f3_q, off_q, i_dmem_rdata);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // request latch and MEM/WB register boundary
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q           <= IDLE;
      addr_q            <= 32'd0;
      wdata_q           <= 32'd0;
      wmask_q           <= 4'd0;
      wen_q             <= 1'b0;
      f3_q              <= 3'd0;
      off_q             <= 2'd0;
      rd_q              <= 5'd0;
      rw_q              <= 1'b0;
      o_wb_valid        <= 1'b0;
      o_wb_reg_write    <= 1'b0;
      o_trap_misaligned <= 1'b0;
      o_wb_rd_addr      <= 5'd0;
      o_wb_data         <= 32'd0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      wmask_q           <= wmask_d;
      wen_q             <= wen_d;
      f3_q              <= f3_d;
      off_q             <= off_d;
      rd_q              <= rd_d;
      rw_q              <= rw_d;
      o_wb_valid        <= wb_valid_d;
      o_wb_reg_write    <= wb_rw_d;
      o_trap_misaligned <= wb_trap_d;
      o_wb_rd_addr      <= wb_rd_d;
      o_wb_data         <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads, stalls, misaligned traps, ALU pass-through, reset.
module tb_mem_lsu;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_alu_result, i_rs2_fwd_data, i_instruction;
  logic [4:0]  i_rd_addr;
  logic        i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg;
  logic        o_stall, o_dmem_req_valid, i_dmem_req_ready;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_wmask;
  logic        o_dmem_wen, i_dmem_rsp_valid;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_valid, o_wb_reg_write, o_trap_misaligned;
  logic [4:0]  o_wb_rd_addr;
  logic [31:0] o_wb_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 i_clk = ~i_clk;

  mem_lsu dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_alu_result(i_alu_result),
    .i_rs2_fwd_data(i_rs2_fwd_data), .i_instruction(i_instruction), .i_rd_addr(i_rd_addr),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
    .i_mem_to_reg(i_mem_to_reg), .o_stall(o_stall), .o_dmem_req_valid(o_dmem_req_valid),
    .i_dmem_req_ready(i_dmem_req_ready), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_wmask(o_dmem_wmask), .o_dmem_wen(o_dmem_wen), .i_dmem_rsp_valid(i_dmem_rsp_valid),
    .i_dmem_rdata(i_dmem_rdata), .o_wb_valid(o_wb_valid), .o_wb_reg_write(o_wb_reg_write),
    .o_trap_misaligned(o_trap_misaligned), .o_wb_rd_addr(o_wb_rd_addr), .o_wb_data(o_wb_data)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_valid = 0; i_alu_result = 0; i_rs2_fwd_data = 0; i_instruction = 0; i_rd_addr = 0;
    i_mem_read = 0; i_mem_write = 0; i_reg_write = 0; i_mem_to_reg = 0;
    i_dmem_req_ready = 0; i_dmem_rsp_valid = 0; i_dmem_rdata = 0;
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rd_en, input logic wr_en, input logic [4:0] rd);
    i_valid = 1; i_instruction = {17'd0, f3, 12'd0}; i_alu_result = addr;
    i_rs2_fwd_data = wd; i_mem_read = rd_en; i_mem_write = wr_en;
    i_reg_write = rd_en; i_mem_to_reg = rd_en; i_rd_addr = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst_n = 0;
    tick(); tick();
    i_rst_n = 1;
    #1;
    if (o_wb_valid !== 1'b0) $display("FAIL reset_wb_valid got=%0h exp=0", o_wb_valid); else pass_cnt++; total_cnt++;
    if (o_dmem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%0h exp=0", o_dmem_req_valid); else pass_cnt++; total_cnt++;
    if (o_stall !== 1'b0) $display("FAIL reset_stall got=%0h exp=0", o_stall); else pass_cnt++; total_cnt++;
    if (o_wb_data !== 32'd0) $display("FAIL reset_wb_data got=%0h exp=0", o_wb_data); else pass_cnt++; total_cnt++;
    if (o_dmem_addr !== 32'd0) $display("FAIL reset_addr got=%0h exp=0", o_dmem_addr); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_wd, input logic [3:0] exp_m);
    present(f3, addr, wd, 1'b0, 1'b1, 5'd9);
    i_dmem_req_ready = 1;
    #1;
    if (o_stall !== 1'b1) $display("FAIL %s_stall0 got=%0h exp=1", nm, o_stall); else pass_cnt++; total_cnt++;
    tick();
    if (o_dmem_req_valid !== 1'b1) $display("FAIL %s_req got=%0h exp=1", nm, o_dmem_req_valid); else pass_cnt++; total_cnt++;
    if (o_dmem_addr !== {addr[31:2], 2'b00}) $display("FAIL %s_addr got=%0h exp=%0h", nm, o_dmem_addr, {addr[31:2], 2'b00}); else pass_cnt++; total_cnt++;
    if (o_dmem_wdata !== exp_wd) $display("FAIL %s_wdata got=%0h exp=%0h", nm, o_dmem_wdata, exp_wd); else pass_cnt++; total_cnt++;
    if (o_dmem_wmask !== exp_m) $display("FAIL %s_wmask got=%0h exp=%0h", nm, o_dmem_wmask, exp_m); else pass_cnt++; total_cnt++;
    if (o_dmem_wen !== 1'b1) $display("FAIL %s_wen got=%0h exp=1", nm, o_dmem_wen); else pass_cnt++; total_cnt++;
    if (o_stall !== 1'b0) $display("FAIL %s_stall1 got=%0h exp=0", nm, o_stall); else pass_cnt++; total_cnt++;
    tick();
    clear_inputs();
    i_dmem_req_ready = 1;
    #1;
    if (o_wb_valid !== 1'b1) $display("FAIL %s_wb_valid got=%0h exp=1", nm, o_wb_valid); else pass_cnt++; total_cnt++;
    if (o_wb_reg_write !== 1'b0) $display("FAIL %s_wb_rw got=%0h exp=0", nm, o_wb_reg_write); else pass_cnt++; total_cnt++;
    if (o_dmem_req_valid !== 1'b0) $display("FAIL %s_req_drop got=%0h exp=0", nm, o_dmem_req_valid); else pass_cnt++; total_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_d);
    present(f3, addr, 32'd0, 1'b1, 1'b0, 5'd5);
    i_dmem_req_ready = 1;
    tick();
    if (o_stall !== 1'b1) $display("FAIL %s_stall_req got=%0h exp=1", nm, o_stall); else pass_cnt++; total_cnt++;
    if (o_dmem_wen !== 1'b0) $display("FAIL %s_wen got=%0h exp=0", nm, o_dmem_wen); else pass_cnt++; total_cnt++;
    tick();
    i_dmem_rsp_valid = 1; i_dmem_rdata = rdata;
    #1;
    if (o_stall !== 1'b0) $display("FAIL %s_stall_rsp got=%0h exp=0", nm, o_stall); else pass_cnt++; total_cnt++;
    tick();
    clear_inputs();
    #1;
    if (o_wb_valid !== 1'b1) $display("FAIL %s_wb_valid got=%0h exp=1", nm, o_wb_valid); else pass_cnt++; total_cnt++;
    if (o_wb_data !== exp_d) $display("FAIL %s_data got=%0h exp=%0h", nm, o_wb_data, exp_d); else pass_cnt++; total_cnt++;
    if (o_wb_rd_addr !== 5'd5) $display("FAIL %s_rd got=%0h exp=5", nm, o_wb_rd_addr); else pass_cnt++; total_cnt++;
    if (o_wb_reg_write !== 1'b1) $display("FAIL %s_rw got=%0h exp=1", nm, o_wb_reg_write); else pass_cnt++; total_cnt++;
    tick();
  endtask

  task automatic test_load_stall();
    present(3'b010, 32'h200, 32'd0, 1'b1, 1'b0, 5'd6);
    tick();
    for (int i = 0; i < 3; i++) begin
      i_dmem_rsp_valid = (i == 0);
      i_dmem_rdata = 32'hBAD0BAD0;
      #1;
      if (o_dmem_req_valid !== 1'b1) $display("FAIL lws_req%0d got=%0h exp=1", i, o_dmem_req_valid); else pass_cnt++; total_cnt++;
      if (o_dmem_addr !== 32'h200) $display("FAIL lws_addr%0d got=%0h exp=200", i, o_dmem_addr); else pass_cnt++; total_cnt++;
      if (o_stall !== 1'b1) $display("FAIL lws_stall%0d got=%0h exp=1", i, o_stall); else pass_cnt++; total_cnt++;
      tick();
      if (o_wb_valid !== 1'b0) $display("FAIL lws_bubble%0d got=%0h exp=0", i, o_wb_valid); else pass_cnt++; total_cnt++;
    end
    i_dmem_rsp_valid = 0;
    i_dmem_req_ready = 1;
    #1;
    if (o_stall !== 1'b1) $display("FAIL lws_stall_acc got=%0h exp=1", o_stall); else pass_cnt++; total_cnt++;
    tick();
    i_dmem_req_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (o_stall !== 1'b1) $display("FAIL lws_rsp_wait%0d got=%0h exp=1", i, o_stall); else pass_cnt++; total_cnt++;
      if (o_dmem_req_valid !== 1'b0) $display("FAIL lws_req_off%0d got=%0h exp=0", i, o_dmem_req_valid); else pass_cnt++; total_cnt++;
      tick();
    end
    i_dmem_rsp_valid = 1; i_dmem_rdata = 32'hCAFEF00D;
    #1;
    if (o_stall !== 1'b0) $display("FAIL lws_stall_end got=%0h exp=0", o_stall); else pass_cnt++; total_cnt++;
    tick();
    clear_inputs();
    #1;
    if (o_wb_valid !== 1'b1) $display("FAIL lws_wb_valid got=%0h exp=1", o_wb_valid); else pass_cnt++; total_cnt++;
    if (o_wb_data !== 32'hCAFEF00D) $display("FAIL lws_data got=%0h exp=cafef00d", o_wb_data); else pass_cnt++; total_cnt++;
    tick();
    if (o_wb_valid !== 1'b0) $display("FAIL lws_single_pulse got=%0h exp=0", o_wb_valid); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_misaligned();
    present(3'b010, 32'h102, 32'd0, 1'b1, 1'b0, 5'd7);
    i_dmem_req_ready = 1;
    #1;
    if (o_stall !== 1'b0) $display("FAIL mis_stall got=%0h exp=0", o_stall); else pass_cnt++; total_cnt++;
    tick();
    clear_inputs();
    #1;
    if (o_wb_valid !== 1'b1) $display("FAIL mis_wb_valid got=%0h exp=1", o_wb_valid); else pass_cnt++; total_cnt++;
    if (o_trap_misaligned !== 1'b1) $display("FAIL mis_trap got=%0h exp=1", o_trap_misaligned); else pass_cnt++; total_cnt++;
    if (o_wb_reg_write !== 1'b0) $display("FAIL mis_rw got=%0h exp=0", o_wb_reg_write); else pass_cnt++; total_cnt++;
    if (o_dmem_req_valid !== 1'b0) $display("FAIL mis_no_req got=%0h exp=0", o_dmem_req_valid); else pass_cnt++; total_cnt++;
    present(3'b001, 32'h101, 32'h1234, 1'b0, 1'b1, 5'd0);
    #1;
    if (o_stall !== 1'b0) $display("FAIL mis_sh_stall got=%0h exp=0", o_stall); else pass_cnt++; total_cnt++;
    tick();
    clear_inputs();
    #1;
    if (o_trap_misaligned !== 1'b1) $display("FAIL mis_sh_trap got=%0h exp=1", o_trap_misaligned); else pass_cnt++; total_cnt++;
    if (o_dmem_req_valid !== 1'b0) $display("FAIL mis_sh_no_req got=%0h exp=0", o_dmem_req_valid); else pass_cnt++; total_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    present(3'b000, 32'h55, 32'd0, 1'b0, 1'b0, 5'd3);
    i_reg_write = 1;
    #1;
    if (o_stall !== 1'b0) $display("FAIL alu_stall got=%0h exp=0", o_stall); else pass_cnt++; total_cnt++;
    tick();
    i_alu_result = 32'h66; i_rd_addr = 5'd4;
    #1;
    if (o_wb_valid !== 1'b1) $display("FAIL alu1_valid got=%0h exp=1", o_wb_valid); else pass_cnt++; total_cnt++;
    if (o_wb_data !== 32'h55) $display("FAIL alu1_data got=%0h exp=55", o_wb_data); else pass_cnt++; total_cnt++;
    if (o_wb_rd_addr !== 5'd3) $display("FAIL alu1_rd got=%0h exp=3", o_wb_rd_addr); else pass_cnt++; total_cnt++;
    if (o_wb_reg_write !== 1'b1) $display("FAIL alu1_rw got=%0h exp=1", o_wb_reg_write); else pass_cnt++; total_cnt++;
    if (o_trap_misaligned !== 1'b0) $display("FAIL alu1_trap got=%0h exp=0", o_trap_misaligned); else pass_cnt++; total_cnt++;
    tick();
    clear_inputs();
    #1;
    if (o_wb_data !== 32'h66) $display("FAIL alu2_data got=%0h exp=66", o_wb_data); else pass_cnt++; total_cnt++;
    if (o_wb_rd_addr !== 5'd4) $display("FAIL alu2_rd got=%0h exp=4", o_wb_rd_addr); else pass_cnt++; total_cnt++;
    tick();
    if (o_wb_valid !== 1'b0) $display("FAIL alu_bubble got=%0h exp=0", o_wb_valid); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_reset_in_rsp();
    present(3'b010, 32'h300, 32'd0, 1'b1, 1'b0, 5'd8);
    i_dmem_req_ready = 1;
    tick();
    tick();
    i_rst_n = 0;
    tick();
    i_rst_n = 1;
    clear_inputs();
    i_dmem_rsp_valid = 1; i_dmem_rdata = 32'h11112222;
    #1;
    if (o_dmem_req_valid !== 1'b0) $display("FAIL rst_rsp_req got=%0h exp=0", o_dmem_req_valid); else pass_cnt++; total_cnt++;
    if (o_dmem_addr !== 32'd0) $display("FAIL rst_rsp_addr got=%0h exp=0", o_dmem_addr); else pass_cnt++; total_cnt++;
    if (o_stall !== 1'b0) $display("FAIL rst_rsp_stall got=%0h exp=0", o_stall); else pass_cnt++; total_cnt++;
    present(3'b000, 32'h77, 32'd0, 1'b0, 1'b0, 5'd2);
    i_reg_write = 1;
    tick();
    clear_inputs();
    #1;
    if (o_wb_valid !== 1'b1) $display("FAIL rst_first_op_valid got=%0h exp=1", o_wb_valid); else pass_cnt++; total_cnt++;
    if (o_wb_data !== 32'h77) $display("FAIL rst_first_op_data got=%0h exp=77 (late rsp leaked)", o_wb_data); else pass_cnt++; total_cnt++;
    tick();
    if (o_wb_valid !== 1'b0) $display("FAIL rst_no_pulse got=%0h exp=0", o_wb_valid); else pass_cnt++; total_cnt++;
  endtask

  initial begin
    test_reset();
    test_store("sw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
    test_store("sb", 3'b000, 32'h103, 32'h000000A5, 32'hA5A5A5A5, 4'b1000);
    test_store("sh", 3'b001, 32'h102, 32'h00001234, 32'h12341234, 4'b1100);
    test_load("lb",  3'b000, 32'h101, 32'h00008000, 32'hFFFFFF80);
    test_load("lbu", 3'b100, 32'h101, 32'h00008000, 32'h00000080);
    test_load("lh",  3'b001, 32'h102, 32'hF00F0000, 32'hFFFFF00F);
    test_load("lhu", 3'b101, 32'h102, 32'hF00F0000, 32'h0000F00F);
    test_load("lw",  3'b010, 32'h104, 32'h12345678, 32'h12345678);
    test_load_stall();
    test_misaligned();
    test_back_to_back();
    test_reset_in_rsp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 i_rst_n  in  1  reset, synchronous, active-low.
REQ-003 i_valid  in  1  EX/MEM entry holds a live instruction.
REQ-004 i_alu_result  in  32  effective address (memory ops) or result (other ops).
REQ-005 i_rs2_fwd_data  in  32  store data, post-forwarding.
REQ-006 i_instruction  in  32  funct3 = bits [14:12] selects access size and sign.
REQ-007 i_rd_addr  in  5; i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg  in  1 each  EX/MEM controls.
REQ-008 o_stall  out  1  hold EX/MEM and all earlier stages.
REQ-009 o_dmem_req_valid  out  1; i_dmem_req_ready  in  1  request handshake.
REQ-010 o_dmem_addr  out  32 (word-aligned, bits[1:0]=0); o_dmem_wdata  out  32; o_dmem_wmask  out  4; o_dmem_wen  out  1.
REQ-011 i_dmem_rsp_valid  in  1; i_dmem_rdata  in  32  load response, full word.
REQ-012 o_wb_valid, o_wb_reg_write, o_trap_misaligned  out  1 each; o_wb_rd_addr  out  5; o_wb_data  out  32  registered MEM/WB outputs.

Function
REQ-013 Memory op = i_valid & (i_mem_read | i_mem_write); non-memory op = i_valid & neither.
REQ-014 FSM states IDLE, REQ, RSP; IDLE->REQ on aligned memory op; REQ->IDLE on store with ready; REQ->RSP on load with ready; RSP->IDLE on i_dmem_rsp_valid.
REQ-015 On entry to REQ: latch word address, wdata, wmask, wen, funct3, addr[1:0], rd; outputs stay stable until accepted.
REQ-016 o_dmem_req_valid = 1 only in REQ; it stays 1 until i_dmem_req_ready; o_dmem_wen = i_mem_write.
REQ-017 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; misaligned ops issue no request and cause no stall.
REQ-018 o_stall = aligned memory op & ~complete; complete = (REQ & ready & store) | (RSP & i_dmem_rsp_valid); o_stall is combinational.
REQ-019 Store: SB replicates byte to all lanes, wmask 0001<<addr[1:0]; SH replicates halfword, wmask 0011<<addr[1:0]; SW wmask 1111.
REQ-020 Load: lane selected by latched addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes word; funct3 011/110/111 treated as word.
REQ-021 WB register loads every cycle: on complete -> o_wb_valid=1, rd, reg_write, data (load result, or 0 for stores).
REQ-022 Non-memory op in IDLE -> next cycle o_wb_valid=1, o_wb_data=i_alu_result, rd and reg_write passed through; latency 1.
REQ-023 Misaligned op -> next cycle o_wb_valid=1, o_trap_misaligned=1, o_wb_reg_write=0.
REQ-024 All other cycles (stalled, idle, i_valid=0) -> o_wb_valid=0, o_wb_reg_write=0, o_trap_misaligned=0 (bubble).
REQ-025 Minimum latency from op presented to o_wb_valid: store 2 cycles, load 3 cycles (ready and rsp_valid both immediate).
REQ-026 i_dmem_rsp_valid outside RSP is ignored; i_dmem_req_ready outside REQ is ignored.
REQ-027 Inputs are held stable by upstream while o_stall=1; the FSM uses only latched copies in REQ and RSP.

Reset
REQ-028 On i_rst_n=0 at a clock edge: FSM -> IDLE; all registered outputs -> 0; latched request fields -> 0.
REQ-029 Reset mid-transaction (REQ or RSP) abandons the access; o_dmem_req_valid drops on the next cycle; a late response is ignored.
REQ-030 The first cycle after reset release accepts a new op.

Verification
REQ-031 SW addr 0x100, data 0xDEADBEEF, ready=1 -> one request: addr 0x100, wmask 1111, wen=1; o_wb_valid=1 two cycles after op, reg_write=0.
REQ-032 SB addr 0x103, data 0x000000A5 -> wdata 0xA5A5A5A5, wmask 1000; SH addr 0x102, data 0x1234 -> wdata 0x12341234, wmask 1100.
REQ-033 LB addr 0x101, rdata 0x0000_80_00 -> o_wb_data 0xFFFFFF80; LBU -> 0x00000080; LH addr 0x102, rdata 0xF00F0000 -> 0xFFFFF00F.
REQ-034 LW with ready low 3 cycles, then rsp delayed 2 cycles -> req_valid and addr stable throughout; o_stall high until the rsp cycle; single o_wb_valid pulse.
REQ-035 LW addr 0x102 -> no request, no stall, o_trap_misaligned=1 next cycle; ADD result 0x55 -> o_wb_data 0x55 next cycle.
REQ-036 Reset asserted in RSP, then rsp_valid arrives -> IDLE, all outputs 0, no o_wb_valid pulse.
